// File: rtl/polyphonic_tone_generator.sv
// -----------------------------------------------------------------------------
// polyphonic_tone_generator
//
// Multi-voice tone synthesiser. A free-running divider produces one tick per
// sample period. On each tick every voice's phase accumulator advances by its
// increment (disabled voices are parked at phase 0). A small FSM then walks
// the voices one per cycle, sums their waveform values, scales the sum back
// to OUT_W bits and hands the result to the DAC path over valid/ready.
//
// Handshake (sample_valid / sample_ready):
//   A transfer happens in every cycle where sample_valid and sample_ready are
//   both 1. sample_out is held stable while sample_valid is 1 and drops valid
//   at the edge after a transfer, unless a new sample is loaded at that same
//   edge. Loading a new sample while the previous one is still untaken
//   overwrites it and raises overrun for exactly one cycle.
//
// Ports:
//   clock_50Mhz     in   system clock
//   reset_n         in   asynchronous active-low reset
//   voice_enable    in   per-voice enable, sampled on the tick
//   voice_increment in   per-voice phase increment, voice i at [i*PHASE_W +: PHASE_W]
//   waveform_mode   in   0 square, 1 saw, 2 triangle, 3 square
//   sample_out      out  mixed sample
//   sample_valid    out  sample_out holds an untaken sample
//   sample_ready    in   consumer accepts the sample
//   active_voices   out  number of voices enabled at the last tick
//   overrun         out  one-cycle pulse when an untaken sample is overwritten
// -----------------------------------------------------------------------------
module polyphonic_tone_generator #(
    parameter int VOICES     = 6,
    parameter int PHASE_W    = 24,
    parameter int OUT_W      = 12,
    parameter int SAMPLE_DIV = 1562
) (
    input  logic                             clock_50Mhz,
    input  logic                             reset_n,
    input  logic [VOICES-1:0]                voice_enable,
    input  logic [VOICES*PHASE_W-1:0]        voice_increment,
    input  logic [1:0]                       waveform_mode,
    output logic [OUT_W-1:0]                 sample_out,
    output logic                             sample_valid,
    input  logic                             sample_ready,
    output logic [$clog2(VOICES+1)-1:0]      active_voices,
    output logic                             overrun
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int AV_W  = $clog2(VOICES + 1);
    // Sum of VOICES values of OUT_W bits each can never exceed this width.
    localparam int SUM_W = OUT_W + AV_W;
    localparam int SHIFT = $clog2(VOICES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2
    } state_t;

    // FSM state is kept as a named enum so checkers can bind to it directly.
    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]   div_count;
    logic               tick;

    logic [PHASE_W-1:0] phase [VOICES];
    logic [VOICES-1:0]  enable_q;
    logic [1:0]         mode_q;

    logic [IDX_W-1:0]   voice_idx;
    logic               last_voice;
    logic [PHASE_W-1:0] sel_phase;
    logic               sel_enable;
    logic [OUT_W-1:0]   sel_wave;
    logic [SUM_W-1:0]   sum;
    logic [OUT_W-1:0]   scaled;

    logic               load;
    logic               transfer;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [AV_W-1:0] popcount(input logic [VOICES-1:0] bits);
        logic [AV_W-1:0] count;
        count = '0;
        for (int i = 0; i < VOICES; i++) begin
            count = count + AV_W'(bits[i]);
        end
        return count;
    endfunction

    // Waveform lookup for one phase value. Reserved mode 3 falls into the
    // default branch and therefore produces a square wave.
    function automatic logic [OUT_W-1:0] wave_value(input logic [PHASE_W-1:0] p,
                                                     input logic [1:0]         mode);
        logic [OUT_W-1:0] tri_base;
        logic [OUT_W-1:0] result;
        tri_base = p[PHASE_W-2 -: OUT_W];
        case (mode)
            2'd1:    result = p[PHASE_W-1 -: OUT_W];
            // Triangle folds the second half of the period back down.
            2'd2:    result = p[PHASE_W-1] ? ~tri_base : tri_base;
            default: result = {OUT_W{p[PHASE_W-1]}};
        endcase
        return result;
    endfunction

    // -------------------------------------------------------------------------
    // Sample-period divider
    // -------------------------------------------------------------------------
    assign tick = (div_count == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            div_count <= '0;
        end else if (tick) begin
            div_count <= '0;
        end else begin
            div_count <= div_count + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Tick capture: phases, enables, mode and the active-voice count all move
    // together at the tick edge so the accumulation pass sees one consistent
    // snapshot no matter how the inputs change afterwards.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < VOICES; i++) begin
                phase[i] <= '0;
            end
            enable_q      <= '0;
            mode_q        <= 2'd0;
            active_voices <= '0;
        end else if (tick) begin
            for (int i = 0; i < VOICES; i++) begin
                // Phase wraps modulo 2^PHASE_W; a disabled voice restarts at 0.
                if (voice_enable[i]) begin
                    phase[i] <= phase[i] + voice_increment[i*PHASE_W +: PHASE_W];
                end else begin
                    phase[i] <= '0;
                end
            end
            enable_q      <= voice_enable;
            mode_q        <= waveform_mode;
            active_voices <= popcount(voice_enable);
        end
    end

    // -------------------------------------------------------------------------
    // Voice selection for the current accumulation step
    // -------------------------------------------------------------------------
    always_comb begin
        sel_phase  = '0;
        sel_enable = 1'b0;
        for (int i = 0; i < VOICES; i++) begin
            if (voice_idx == IDX_W'(i)) begin
                sel_phase  = phase[i];
                sel_enable = enable_q[i];
            end
        end
    end

    assign sel_wave   = wave_value(sel_phase, mode_q);
    assign last_voice = (voice_idx == IDX_W'(VOICES - 1));
    assign scaled     = OUT_W'(sum >> SHIFT);

    // -------------------------------------------------------------------------
    // FSM: IDLE waits for the tick, ACCUM walks the voices, SCALE loads output
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick)       state_next = ACCUM;
            ACCUM:   if (last_voice) state_next = SCALE;
            SCALE:                   state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Datapath registers driven by the FSM. The sum is cleared at the tick
    // edge, i.e. on entry to ACCUM.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            voice_idx <= '0;
            sum       <= '0;
        end else if (state == IDLE && tick) begin
            voice_idx <= '0;
            sum       <= '0;
        end else if (state == ACCUM) begin
            voice_idx <= voice_idx + IDX_W'(1);
            if (sel_enable) begin
                sum <= sum + SUM_W'(sel_wave);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output handshake
    // -------------------------------------------------------------------------
    assign load     = (state == SCALE);
    assign transfer = sample_valid && sample_ready;

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            // A load that coincides with a transfer is not an overrun: the
            // old sample leaves in the same cycle the new one arrives.
            overrun <= load && sample_valid && !sample_ready;
            if (load) begin
                sample_out   <= scaled;
                sample_valid <= 1'b1;
            end else if (transfer) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_polyphonic_tone_generator.sv
// -----------------------------------------------------------------------------
// tb_polyphonic_tone_generator
//
// Directed bench for polyphonic_tone_generator with SAMPLE_DIV = 16.
// Edge numbering: after reset release (at a falling edge) the first rising
// edge is edge 0. The tick acts at edge 15 and the first sample is visible
// after edge 22; later samples follow every 16 edges.
// -----------------------------------------------------------------------------
module tb_polyphonic_tone_generator;

    localparam int VOICES     = 6;
    localparam int PHASE_W    = 24;
    localparam int OUT_W      = 12;
    localparam int SAMPLE_DIV = 16;
    localparam int AV_W       = $clog2(VOICES + 1);

    logic                      clk;
    logic                      rst_n;
    logic [VOICES-1:0]         enable;
    logic [VOICES*PHASE_W-1:0] incr;
    logic [1:0]                mode;
    logic [OUT_W-1:0]          sample;
    logic                      valid;
    logic                      ready;
    logic [AV_W-1:0]           active;
    logic                      ovr;

    int total;
    int bad;

    polyphonic_tone_generator #(
        .VOICES    (VOICES),
        .PHASE_W   (PHASE_W),
        .OUT_W     (OUT_W),
        .SAMPLE_DIV(SAMPLE_DIV)
    ) dut (
        .clock_50Mhz    (clk),
        .reset_n        (rst_n),
        .voice_enable   (enable),
        .voice_increment(incr),
        .waveform_mode  (mode),
        .sample_out     (sample),
        .sample_valid   (valid),
        .sample_ready   (ready),
        .active_voices  (active),
        .overrun        (ovr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_voice(input int v, input logic [PHASE_W-1:0] inc);
        incr[v*PHASE_W +: PHASE_W] = inc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        enable = '0; incr = '0; mode = 2'd0; ready = 1'b1;
        rst_n = 1'b0;
        #1;
        total++; if (sample !== 12'h000) begin bad++; $display("FAIL reset_sample: got %h expected 000", sample); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
        total++; if (active !== 3'd0) begin bad++; $display("FAIL reset_active: got %0d expected 0", active); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", ovr); end
        do_reset();
        repeat (22) @(posedge clk);
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL first_early: valid got %b expected 0 after edge 21", valid); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b expected 1 after edge 22", valid); end
        total++; if (sample !== 12'h000) begin bad++; $display("FAIL first_sample: got %h expected 000", sample); end
        total++; if (active !== 3'd0) begin bad++; $display("FAIL first_active: got %0d expected 0", active); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL first_taken: valid got %b expected 0", valid); end
    endtask

    task automatic test_saw();
        logic [OUT_W-1:0] exp;
        enable = 6'b000001; incr = '0; set_voice(0, 24'h100000); mode = 2'd1; ready = 1'b1;
        do_reset();
        repeat (23) @(posedge clk);
        #1;
        for (int j = 1; j <= 17; j++) begin
            exp = OUT_W'(((j * 256) % 4096) >> 3);
            total++; if (valid !== 1'b1 || sample !== exp) begin
                bad++; $display("FAIL saw_%0d: got %h valid %b expected %h valid 1", j, sample, valid, exp);
            end
            if (j == 1) begin
                total++; if (active !== 3'd1) begin bad++; $display("FAIL saw_active: got %0d expected 1", active); end
            end
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_square();
        logic [OUT_W-1:0] exp;
        enable = 6'b111111; mode = 2'd0; ready = 1'b1;
        for (int v = 0; v < VOICES; v++) set_voice(v, 24'h800000);
        do_reset();
        repeat (23) @(posedge clk);
        #1;
        total++; if (active !== 3'd6) begin bad++; $display("FAIL square_active: got %0d expected 6", active); end
        for (int j = 1; j <= 4; j++) begin
            exp = (j % 2 == 1) ? 12'hBFF : 12'h000;
            total++; if (valid !== 1'b1 || sample !== exp) begin
                bad++; $display("FAIL square_%0d: got %h valid %b expected %h valid 1", j, sample, valid, exp);
            end
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_triangle();
        logic [OUT_W-1:0] tri_tab [4];
        tri_tab[0] = 12'h100; tri_tab[1] = 12'h1FF; tri_tab[2] = 12'h0FF; tri_tab[3] = 12'h000;
        enable = 6'b000100; incr = '0; set_voice(2, 24'h400000); mode = 2'd2; ready = 1'b1;
        do_reset();
        repeat (23) @(posedge clk);
        #1;
        for (int j = 0; j < 8; j++) begin
            total++; if (valid !== 1'b1 || sample !== tri_tab[j % 4]) begin
                bad++; $display("FAIL tri_%0d: got %h valid %b expected %h valid 1", j, sample, valid, tri_tab[j % 4]);
            end
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_overrun();
        int pulses;
        enable = 6'b000001; incr = '0; set_voice(0, 24'h100000); mode = 2'd1; ready = 1'b0;
        do_reset();
        repeat (23) @(posedge clk);
        #1;
        total++; if (valid !== 1'b1 || sample !== 12'h020) begin bad++; $display("FAIL ovr_first: got %h valid %b expected 020 valid 1", sample, valid); end
        pulses = 0;
        for (int e = 23; e <= 37; e++) begin
            @(posedge clk); #1;
            if (ovr === 1'b1) pulses++;
            total++; if (valid !== 1'b1 || sample !== 12'h020) begin
                bad++; $display("FAIL ovr_hold_%0d: got %h valid %b expected 020 valid 1", e, sample, valid);
            end
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL ovr_early: got %0d pulses expected 0", pulses); end
        @(posedge clk); #1;
        total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b expected 1", ovr); end
        total++; if (valid !== 1'b1 || sample !== 12'h040) begin bad++; $display("FAIL ovr_overwrite: got %h valid %b expected 040 valid 1", sample, valid); end
        @(posedge clk); #1;
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_width: got %b expected 0", ovr); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL ovr_still_valid: got %b expected 1", valid); end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: valid got %b expected 0", valid); end
    endtask

    task automatic test_back_to_back();
        enable = 6'b000001; incr = '0; set_voice(0, 24'h100000); mode = 2'd1; ready = 1'b0;
        do_reset();
        repeat (23) @(posedge clk);
        #1;
        total++; if (valid !== 1'b1 || sample !== 12'h020) begin bad++; $display("FAIL b2b_first: got %h valid %b expected 020 valid 1", sample, valid); end
        repeat (15) @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk); #1;
        total++; if (valid !== 1'b1 || sample !== 12'h040) begin bad++; $display("FAIL b2b_load: got %h valid %b expected 040 valid 1", sample, valid); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b expected 0", ovr); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_taken: valid got %b expected 0", valid); end
    endtask

    task automatic test_disable();
        enable = 6'b000001; incr = '0; set_voice(0, 24'h100000); mode = 2'd1; ready = 1'b1;
        do_reset();
        repeat (23) @(posedge clk);
        #1;
        total++; if (sample !== 12'h020) begin bad++; $display("FAIL dis_s1: got %h expected 020", sample); end
        repeat (16) @(posedge clk);
        #1;
        total++; if (sample !== 12'h040) begin bad++; $display("FAIL dis_s2: got %h expected 040", sample); end
        enable = 6'b000000;
        repeat (16) @(posedge clk);
        #1;
        total++; if (valid !== 1'b1 || sample !== 12'h000) begin bad++; $display("FAIL dis_off: got %h valid %b expected 000 valid 1", sample, valid); end
        total++; if (active !== 3'd0) begin bad++; $display("FAIL dis_active0: got %0d expected 0", active); end
        enable = 6'b000001;
        repeat (16) @(posedge clk);
        #1;
        total++; if (valid !== 1'b1 || sample !== 12'h020) begin bad++; $display("FAIL dis_restart: got %h valid %b expected 020 valid 1", sample, valid); end
        total++; if (active !== 3'd1) begin bad++; $display("FAIL dis_active1: got %0d expected 1", active); end
    endtask

    task automatic test_reset_mid_accum();
        int early;
        enable = 6'b000001; incr = '0; set_voice(0, 24'h100000); mode = 2'd1; ready = 1'b0;
        do_reset();
        repeat (23) @(posedge clk);
        #1;
        total++; if (valid !== 1'b1 || sample !== 12'h020) begin bad++; $display("FAIL mid_pre: got %h valid %b expected 020 valid 1", sample, valid); end
        // Edge 33 lies inside the accumulation pass of the second tick.
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (sample !== 12'h000 || valid !== 1'b0) begin bad++; $display("FAIL mid_clear: got %h valid %b expected 000 valid 0", sample, valid); end
        total++; if (active !== 3'd0 || ovr !== 1'b0) begin bad++; $display("FAIL mid_clear_status: active %0d overrun %b expected 0 0", active, ovr); end
        ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        early = 0;
        for (int e = 0; e <= 21; e++) begin
            @(posedge clk); #1;
            if (valid !== 1'b0) early++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL mid_spurious: got %0d valid cycles expected 0", early); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b1 || sample !== 12'h020) begin bad++; $display("FAIL mid_after: got %h valid %b expected 020 valid 1", sample, valid); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        enable = '0; incr = '0; mode = 2'd0; ready = 1'b1;
        test_reset();
        test_saw();
        test_square();
        test_triangle();
        test_overrun();
        test_back_to_back();
        test_disable();
        test_reset_mid_accum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
